// File: rtl/bcd_pkg.sv
// Shared types and constants for the signed binary to BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Internal digit count: ceil(width * log10(2)), never fewer than the presented digits.
    function automatic int unsigned calc_ni(input int unsigned width, input int unsigned digits);
        longint unsigned n;
        n = (longint'(width) * 64'd301029996 + 64'd999999999) / 64'd1000000000;
        if (n < longint'(digits)) begin
            n = longint'(digits);
        end
        return 32'(n);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] value,
    output logic [3:0] adjusted
);

    assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/signed_bcd_converter.sv
// Sequential signed binary to packed BCD converter (shift-add-3).
// Define BCD_BLANK_EN to replace leading zero digits with the blank code.
module signed_bcd_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4,
    localparam int unsigned SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      num,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    input  logic [SEL_W-1:0]      digit_sel,
    output logic [3:0]            digit
);

    localparam int unsigned NI = calc_ni(WIDTH, DIGITS);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    mag_q, mag_d, mag_shift;
    logic [4*NI-1:0]     scr_q, scr_d, scr_adj, scr_shift;
    logic                neg_q, neg_d;
    logic                sign_q, sign_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_res;
    logic                ovf_q, ovf_d, ovf_res;
`ifdef BCD_BLANK_EN
    logic                lead;
`endif

    for (genvar g = 0; g < NI; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .value    (scr_q[4*g +: 4]),
            .adjusted (scr_adj[4*g +: 4])
        );
    end

    assign {scr_shift, mag_shift} = {scr_adj, mag_q} << 1;

    // Result as it will look after the final shift; only consumed on the DONE entry edge.
    always_comb begin
        ovf_res = 1'b0;
        for (int i = DIGITS; i < NI; i++) begin
            if (scr_shift[4*i +: 4] != 4'd0) begin
                ovf_res = 1'b1;
            end
        end
        bcd_res = scr_shift[4*DIGITS-1:0];
        if (ovf_res) begin
            bcd_res = {DIGITS{4'h9}};
        end
`ifdef BCD_BLANK_EN
        else begin
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && bcd_res[4*i +: 4] == 4'd0) begin
                    bcd_res[4*i +: 4] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        neg_d   = neg_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StShift;
                    neg_d   = num[WIDTH-1];
                    // Negation in WIDTH bits maps the most negative value to 2^(WIDTH-1).
                    mag_d   = num[WIDTH-1] ? -num : num;
                    scr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                scr_d = scr_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StDone;
                    sign_d  = neg_q;
                    bcd_d   = bcd_res;
                    ovf_d   = ovf_res;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mag_q   <= '0;
            scr_q   <= '0;
            neg_q   <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            neg_q   <= neg_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == StShift);
    assign done     = (state_q == StDone);
    assign sign     = sign_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

    always_comb begin
        digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel == SEL_W'(i)) begin
                digit = bcd_q[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Randomised self-checking bench for signed_bcd_converter (4- and 3-digit instances).
// Expectations follow BCD_BLANK_EN when it is defined.
module tb_signed_bcd_converter;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [12:0] num;
    logic [1:0]  sel4, sel3;
    logic        busy, done, sign, ovf;
    logic [15:0] bcd;
    logic [3:0]  digit;
    logic        busy3, done3, sign3, ovf3;
    logic [11:0] bcd3;
    logic [3:0]  digit3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    signed_bcd_converter #(.WIDTH(13), .DIGITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .num(num), .busy(busy), .done(done),
        .sign(sign), .bcd(bcd), .overflow(ovf), .digit_sel(sel4), .digit(digit)
    );

    signed_bcd_converter #(.WIDTH(13), .DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .num(num), .busy(busy3), .done(done3),
        .sign(sign3), .bcd(bcd3), .overflow(ovf3), .digit_sel(sel3), .digit(digit3)
    );

    // Decimal reference: magnitude split by /10 and %10, saturated past 10^nd - 1.
    function automatic logic [15:0] model_bcd(input int v, input int nd, output logic o);
        int mag, lim;
        logic [15:0] r;
        bit lead;
        mag = (v < 0) ? -v : v;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        r = '0;
        if (mag > lim - 1) begin
            o = 1'b1;
            for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
        end else begin
            o = 1'b0;
            for (int i = 0; i < nd; i++) begin
                r[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
`ifdef BCD_BLANK_EN
            lead = 1'b1;
            for (int i = nd - 1; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`endif
        end
        return r;
    endfunction

    function automatic int sval(input logic [12:0] x);
        return int'($signed(x));
    endfunction

    // Starts one conversion and waits (bounded) for done; num is scrambled during SHIFT.
    task automatic convert(input logic [12:0] v, output int cyc, output int busy_cnt);
        @(posedge clk); #1;
        start = 1'b1;
        num   = v;
        @(posedge clk); #1;
        start = 1'b0;
        num   = 13'($urandom);
        cyc = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        num     = '0;
        sel4    = '0;
        sel3    = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, sign, ovf, bcd} !== 20'h0)
            $display("FAIL reset4: got busy=%b done=%b sign=%b ovf=%b bcd=%h, want all 0",
                     busy, done, sign, ovf, bcd);
        else passed++;
        total++;
        if ({busy3, done3, sign3, ovf3, bcd3} !== 16'h0)
            $display("FAIL reset3: got busy=%b done=%b bcd=%h, want all 0", busy3, done3, bcd3);
        else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [12:0] vals[8] = '{13'd1234, 13'h1FFF, 13'h1000, 13'd0, 13'd999, 13'd1000,
                                 13'd4095, 13'd7};
        logic [15:0] e4, e3;
        logic        o4, o3;
        logic [15:0] held;
        int cyc, bc;
        foreach (vals[k]) begin
            e4 = model_bcd(sval(vals[k]), 4, o4);
            e3 = model_bcd(sval(vals[k]), 3, o3);
            convert(vals[k], cyc, bc);
            total++;
            if (cyc != 14 || bc != 13)
                $display("FAIL latency %0d: done at cycle %0d busy cycles %0d, want 14 and 13",
                         sval(vals[k]), cyc, bc);
            else passed++;
            total++;
            if (sign !== vals[k][12] || bcd !== e4 || ovf !== o4)
                $display("FAIL result4 %0d: got sign=%b bcd=%h ovf=%b, want %b %h %b",
                         sval(vals[k]), sign, bcd, ovf, vals[k][12], e4, o4);
            else passed++;
            total++;
            if (sign3 !== vals[k][12] || bcd3 !== e3[11:0] || ovf3 !== o3)
                $display("FAIL result3 %0d: got sign=%b bcd=%h ovf=%b, want %b %h %b",
                         sval(vals[k]), sign3, bcd3, ovf3, vals[k][12], e3[11:0], o3);
            else passed++;
            for (int i = 0; i < 4; i++) begin
                sel4 = 2'(i);
                #1;
                total++;
                if (digit !== e4[4*i +: 4])
                    $display("FAIL digit %0d sel %0d: got %h want %h", sval(vals[k]), i, digit,
                             e4[4*i +: 4]);
                else passed++;
            end
            sel3 = 2'd3;
            #1;
            total++;
            if (digit3 !== 4'h0) $display("FAIL digit_sel_range: got %h want 0", digit3);
            else passed++;
        end
        // Results hold while idle and num changes.
        held = bcd;
        repeat (5) begin
            @(posedge clk); #1;
            num = 13'($urandom);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== held)
            $display("FAIL hold: got busy=%b done=%b bcd=%h, want 0 0 %h", busy, done, bcd, held);
        else passed++;
    endtask

    task automatic test_random;
        logic [12:0] v;
        logic [15:0] e4, e3;
        logic        o4, o3;
        int cyc, bc;
        for (int n = 0; n < 30; n++) begin
            v = 13'($urandom);
            e4 = model_bcd(sval(v), 4, o4);
            e3 = model_bcd(sval(v), 3, o3);
            convert(v, cyc, bc);
            total++;
            if (cyc != 14 || sign !== v[12] || bcd !== e4 || ovf !== o4 ||
                sign3 !== v[12] || bcd3 !== e3[11:0] || ovf3 !== o3)
                $display("FAIL random %0d: cyc=%0d sign=%b bcd=%h ovf=%b bcd3=%h ovf3=%b, want 14 %b %h %b %h %b",
                         sval(v), cyc, sign, bcd, ovf, bcd3, ovf3, v[12], e4, o4, e3[11:0], o3);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] e;
        logic        o;
        int t, t1;
        @(posedge clk); #1;
        start = 1'b1;
        num   = 13'd5;
        @(posedge clk); #1;
        num = 13'd42;
        t = 1;
        while (done !== 1'b1 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        t1 = t;
        e = model_bcd(5, 4, o);
        total++;
        if (t1 != 14 || bcd !== e)
            $display("FAIL b2b_first: done at %0d bcd=%h, want 14 %h", t1, bcd, e);
        else passed++;
        @(posedge clk); #1;
        t++;
        start = 1'b0;
        num   = 13'd7;
        while (done !== 1'b1 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        e = model_bcd(42, 4, o);
        total++;
        if (t - t1 != 14 || bcd !== e)
            $display("FAIL b2b_second: spacing %0d bcd=%h, want 14 %h", t - t1, bcd, e);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_ignored_start;
        logic [15:0] e;
        logic        o;
        int t;
        e = model_bcd(300, 4, o);
        @(posedge clk); #1;
        start = 1'b1;
        num   = 13'd300;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        while (done !== 1'b1 && t < 40) begin
            start = (t == 3 || t == 7) ? 1'b1 : 1'b0;
            num   = 13'd1;
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        total++;
        if (t != 14 || bcd !== e)
            $display("FAIL ignored_start: done at %0d bcd=%h, want 14 %h", t, bcd, e);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL ignored_queue: got busy=%b done=%b, want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        @(posedge clk); #1;
        start = 1'b1;
        num   = 13'd777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        total++;
        if (busy !== 1'b1) $display("FAIL mid_busy: got busy=%b want 1", busy);
        else passed++;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        total++;
        if ({busy, done, sign, ovf, bcd} !== 20'h0)
            $display("FAIL mid_reset: got busy=%b done=%b sign=%b ovf=%b bcd=%h, want all 0",
                     busy, done, sign, ovf, bcd);
        else passed++;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done) $display("FAIL mid_no_done: activity seen after reset, want none");
        else passed++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_ignored_start;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/signed_bcd_converter.md
# signed_bcd_converter

Sequential, parametrised signed-binary to BCD converter for the seven-segment display path. Accepts a two's-complement value with a start/done handshake, converts its magnitude to DIGITS packed BCD digits by iterative shift-add-3 (double dabble), and holds sign, digits and an overflow flag until the next conversion. A digit-select port returns one registered digit per cycle to the display scanner. Replaces the per-digit divide/modulo path and is correct for the most negative input.

## Interface
- WIDTH, 13: input width in bits, two's complement, minimum 2.
- DIGITS, 4: number of BCD digits presented, minimum 1.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request a conversion of num; sampled only when busy=0.
- num  in  WIDTH  signed input value; sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress (SHIFT state).
- done  out  1  one-cycle pulse; result outputs valid from this cycle on.
- sign  out  1  1 = converted value was negative.
- bcd  out  4*DIGITS  packed result; digit 0 (units) in bits [3:0].
- overflow  out  1  magnitude exceeded 10^DIGITS − 1.
- digit_sel  in  $clog2(DIGITS), minimum 1  digit index for digit.
- digit  out  4  combinational read of bcd digit digit_sel.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Accept: start=1 in IDLE or DONE → capture sign=num[WIDTH−1], mag=|num| as WIDTH-bit unsigned (−2^(WIDTH−1) → 2^(WIDTH−1), no truncation); clear scratch BCD and iteration counter; go to SHIFT.
- SHIFT: each cycle, every scratch digit ≥5 gets +3, then {scratch, mag} shifts left by one. Scratch holds NI = ceil(WIDTH·log10 2) internal digits (minimum DIGITS). After WIDTH iterations → DONE.
- DONE entry edge: register sign, bcd, overflow. overflow=1 iff any internal digit at index ≥ DIGITS is nonzero; then bcd saturates to all 9s. done=1 for the DONE cycle only.
- DONE: start=1 → new conversion (back-to-back); else → IDLE.
- start with busy=1 is ignored, not queued; num changes during SHIFT have no effect.
- Results (sign, bcd, overflow) hold until the next DONE entry edge or reset.
- digit: bcd digit digit_sel; digit_sel ≥ DIGITS → 4'h0.
- Zero input → sign=0, bcd=0, overflow=0.

## Timing
- Reset values: busy=0, done=0, sign=0, bcd=0, overflow=0, state IDLE.
- Latency: start accepted at edge E → busy high cycles E+1..E+WIDTH, done high cycle E+WIDTH+1 (WIDTH+1 cycles).
- Throughput: one conversion per WIDTH+1 cycles with start held.
- reset_n low at any edge, including mid-SHIFT or in DONE: next cycle all outputs at reset values, no done pulse, in-flight conversion discarded. reset_n has priority over start.
- digit follows digit_sel combinationally, 0 cycles.

## Configuration
- BCD_BLANK_EN defined: leading-zero blanking on bcd and digit. Every digit above the most significant nonzero digit reads 4'hF (blank code); digit 0 never blanked; zero → 4'hF…F0. Applied on the DONE entry edge; not applied to saturated overflow results.
- Undefined: leading zeros read 4'h0; no blank code produced.

## Structure
- Package bcd_pkg: state enum (IDLE, SHIFT, DONE), BLANK_CODE = 4'hF, constant function for internal digit count NI from WIDTH.
- Sub-module bcd_digit_adjust: one 4-bit digit in, +3 if ≥5, out; instantiated NI times by generate.
- Top holds FSM, iteration counter ($clog2(WIDTH+1) bits), magnitude/scratch shift register, result registers, digit mux.

## Test plan
- WIDTH=13, DIGITS=4, num=1234, start one cycle → busy cycles 1..13, done cycle 14, bcd=16'h1234, sign=0, overflow=0.
- num=13'h1FFF (−1) → sign=1, bcd=16'h0001; num=13'h1000 (−4096) → sign=1, bcd=16'h4096.
- WIDTH=13, DIGITS=3, num=1000 → overflow=1, bcd=12'h999; then num=999 → overflow=0, bcd=12'h999.
- start held high, num=5 then 42 → done pulses exactly 14 cycles apart, bcd 16'h0005 then 16'h0042; start pulses during busy ignored.
- reset_n low at SHIFT iteration 6 → next cycle busy=0, done=0, bcd=0; no done pulse follows.
- BCD_BLANK_EN defined, num=7 → bcd=16'hFFF7, digit_sel=3 → digit=4'hF; num=0 → 16'hFFF0.
